// File: rtl/credit_fifo_rx.sv
// rtl/credit_fifo_rx.sv - credit-based stream receiver: FWFT buffer with credit return
//
// Ports:
//   clk_i       clock, all logic on the rising edge
//   rst_i       synchronous reset, active-high
//   valid_i     transmitter push strobe (no back-pressure; credit-governed)
//   data_i      pushed word, sampled when valid_i=1
//   credit_o    one-cycle pulse per credit returned to the transmitter
//   data_o      head-of-FIFO word (first-word fall-through)
//   valid_o     FIFO not empty
//   ready_i     downstream accepts the head word when valid_o & ready_i
//   count_o     current occupancy, 0..BUFFER_DEPTH
//   overflow_o  sticky flag: a push arrived while full and was dropped
module credit_fifo_rx #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int LOG_DEPTH    = $clog2(BUFFER_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  credit_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [LOG_DEPTH:0]    count_o,
    output logic                  overflow_o
);

    typedef logic [LOG_DEPTH:0] ptr_t;

    localparam ptr_t DEPTH_W = ptr_t'(BUFFER_DEPTH);
    localparam ptr_t ONE_W   = ptr_t'(1);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

    ptr_t wr_q;
    ptr_t rd_q;
    ptr_t pend_q;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic issue;
    ptr_t wr_next;
    ptr_t rd_next;
    ptr_t pend_next;

    // One extra pointer bit distinguishes full from empty when indices match.
    assign full  = (wr_q ^ rd_q) == DEPTH_W;
    assign pop   = valid_o & ready_i;
    // A pop in the same cycle frees the slot, so a push is accepted even when full.
    assign push  = valid_i & (~full | pop);
    assign drop  = valid_i & full & ~pop;
    assign issue = (pend_q != '0);

    assign wr_next   = push  ? wr_q + ONE_W : wr_q;
    assign rd_next   = pop   ? rd_q + ONE_W : rd_q;
    assign pend_next = pend_q + (pop ? ONE_W : '0) - (issue ? ONE_W : '0);

    assign data_o = mem[rd_q[LOG_DEPTH-1:0]];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_q[LOG_DEPTH-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_o    <= '0;
            valid_o    <= 1'b0;
            credit_o   <= 1'b0;
            overflow_o <= 1'b0;
            // The whole buffer is owed to the transmitter after reset.
            pend_q     <= DEPTH_W;
        end else begin
            wr_q     <= wr_next;
            rd_q     <= rd_next;
            // Status flags are computed from next pointers so they stay registered.
            count_o  <= wr_next - rd_next;
            valid_o  <= (wr_next != rd_next);
            credit_o <= issue;
            pend_q   <= pend_next;
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_credit_fifo_rx.sv
// tb/tb_credit_fifo_rx.sv - scoreboard testbench for credit_fifo_rx
module tb_credit_fifo_rx;

    localparam int DW = 8;
    localparam int D  = 4;
    localparam int LD = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          credit_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [LD:0]   count_o;
    logic          overflow_o;

    credit_fifo_rx #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors   = 0;
    int miscomp   = 0;
    int tx_credits = 0;
    int total_credits = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_w;

    // Advance one clock; sample 1 time unit after the edge and tally credits.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (credit_o === 1'b1) begin
            tx_credits++;
            total_credits++;
        end
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        tick();
        tick();
        rst_i = 1'b0;
        sb.delete();
        tx_credits    = 0;
        total_credits = 0;
    endtask

    // Reset, let the grant run out, push 0xA1..0xA4 with no draining.
    task automatic fill_a();
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = 8'hA1 + 8'(i);
            sb.push_back(data_i);
            tx_credits--;
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (count_o !== 3'd0 || valid_o !== 1'b0 || credit_o !== 1'b0 || overflow_o !== 1'b0) begin
            miscomp++;
            $display("FAIL reset_state: count=%0d valid=%b credit=%b ovf=%b, want 0 0 0 0",
                     count_o, valid_o, credit_o, overflow_o);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++;
            if (credit_o !== (i < D) || count_o !== 3'd0 || valid_o !== 1'b0) begin
                miscomp++;
                $display("FAIL initial_grant cycle %0d: credit=%b count=%0d valid=%b, want %b 0 0",
                         i, credit_o, count_o, valid_o, (i < D));
            end
        end
        vectors++;
        if (total_credits !== D) begin
            miscomp++;
            $display("FAIL grant_total: got %0d want %0d", total_credits, D);
        end
    endtask

    task automatic test_fill();
        fill_a();
        vectors++;
        if (count_o !== 3'd4 || valid_o !== 1'b1 || data_o !== 8'hA1 || total_credits !== D) begin
            miscomp++;
            $display("FAIL fill: count=%0d valid=%b data=%h credits=%0d, want 4 1 a1 %0d",
                     count_o, valid_o, data_o, total_credits, D);
        end
    endtask

    task automatic test_single_pop();
        fill_a();
        ready_i = 1'b1;
        exp_w = sb.pop_front();
        vectors++;
        if (data_o !== exp_w) begin
            miscomp++;
            $display("FAIL pop_head: got %h want %h", data_o, exp_w);
        end
        tick();
        ready_i = 1'b0;
        vectors++;
        if (data_o !== 8'hA2 || count_o !== 3'd3 || credit_o !== 1'b0) begin
            miscomp++;
            $display("FAIL after_pop: data=%h count=%0d credit=%b, want a2 3 0", data_o, count_o, credit_o);
        end
        tick();
        vectors++;
        if (credit_o !== 1'b1) begin
            miscomp++;
            $display("FAIL pop_credit: credit=%b want 1", credit_o);
        end
        tick();
        vectors++;
        if (credit_o !== 1'b0 || total_credits !== D + 1) begin
            miscomp++;
            $display("FAIL pop_credit_single: credit=%b total=%0d, want 0 %0d", credit_o, total_credits, D + 1);
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        ready_i = 1'b1;
        while (valid_o === 1'b1 && guard < 20) begin
            vectors++;
            if (sb.size() == 0) begin
                miscomp++;
                $display("FAIL %s_extra_word: got %h want none", tag, data_o);
            end else begin
                exp_w = sb.pop_front();
                if (data_o !== exp_w) begin
                    miscomp++;
                    $display("FAIL %s_order: got %h want %h", tag, data_o, exp_w);
                end
            end
            tick();
            guard++;
        end
        ready_i = 1'b0;
        vectors++;
        if (sb.size() != 0 || valid_o !== 1'b0) begin
            miscomp++;
            $display("FAIL %s_drain: left %0d words valid=%b, want 0 0", tag, sb.size(), valid_o);
        end
    endtask

    task automatic test_overflow();
        fill_a();
        valid_i = 1'b1;
        data_i  = 8'hFF;
        tick();
        valid_i = 1'b0;
        vectors++;
        if (overflow_o !== 1'b1 || count_o !== 3'd4) begin
            miscomp++;
            $display("FAIL overflow_set: ovf=%b count=%0d, want 1 4", overflow_o, count_o);
        end
        tick();
        tick();
        drain("overflow");
        vectors++;
        if (overflow_o !== 1'b1) begin
            miscomp++;
            $display("FAIL overflow_sticky: ovf=%b want 1", overflow_o);
        end
    endtask

    task automatic test_push_pop_full();
        fill_a();
        valid_i = 1'b1;
        data_i  = 8'hB0;
        ready_i = 1'b1;
        exp_w = sb.pop_front();
        vectors++;
        if (data_o !== exp_w) begin
            miscomp++;
            $display("FAIL full_pp_head: got %h want %h", data_o, exp_w);
        end
        sb.push_back(8'hB0);
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        vectors++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
            miscomp++;
            $display("FAIL full_pp: count=%0d ovf=%b, want 4 0", count_o, overflow_o);
        end
        drain("full_pp");
    endtask

    task automatic test_stream();
        int sent;
        int guard;
        do_reset();
        sent  = 0;
        guard = 0;
        while ((sent < 12 || sb.size() != 0) && guard < 500) begin
            valid_i = 1'b0;
            if (sent < 12 && tx_credits > 0 && $urandom_range(0, 3) != 0) begin
                valid_i = 1'b1;
                data_i  = 8'(sent);
                sb.push_back(data_i);
                tx_credits--;
                sent++;
            end
            ready_i = 1'($urandom_range(0, 1));
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscomp++;
                    $display("FAIL stream_extra_word: got %h want none", data_o);
                end else begin
                    exp_w = sb.pop_front();
                    if (data_o !== exp_w) begin
                        miscomp++;
                        $display("FAIL stream_order: got %h want %h", data_o, exp_w);
                    end
                end
            end
            tick();
            guard++;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        vectors++;
        if (guard >= 500) begin
            miscomp++;
            $display("FAIL stream_timeout: sent=%0d left=%0d, want 12 0", sent, sb.size());
        end
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (overflow_o !== 1'b0 || total_credits !== 16 || count_o !== 3'd0) begin
            miscomp++;
            $display("FAIL stream_end: ovf=%b credits=%0d count=%0d, want 0 16 0",
                     overflow_o, total_credits, count_o);
        end
        // Mid-stream reset with words buffered.
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = 8'h50 + 8'(i);
            tick();
        end
        valid_i = 1'b0;
        rst_i   = 1'b1;
        tick();
        vectors++;
        if (valid_o !== 1'b0 || count_o !== 3'd0) begin
            miscomp++;
            $display("FAIL midreset: valid=%b count=%0d, want 0 0", valid_o, count_o);
        end
        rst_i = 1'b0;
        total_credits = 0;
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (total_credits !== D) begin
            miscomp++;
            $display("FAIL midreset_credits: got %0d want %0d", total_credits, D);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        test_reset();
        test_fill();
        test_single_pop();
        test_overflow();
        test_push_pop_full();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
